// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and the end-of-program sentinel instruction.
package pipe_ctrl_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;
    localparam logic [1:0] HALT     = 2'd3;

    localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the load sitting in ID/EX writes a
// register that the instruction in IF/ID needs as a source.
module hazard_detect (
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    output logic       load_use
);

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline registers. Produces PC / IF/ID
// enables, flush and bubble requests and the shared stage enable, and owns
// the end-of-program drain/halt and memory-timeout fault handling.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_inst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_en,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] stall_count
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]       state, next_state;
    logic [DRN_W-1:0] drain_cnt, next_drain_cnt;
    logic [TMO_W-1:0] tmo_cnt, next_tmo_cnt;
    logic             set_fault;
    logic             load_use;
    logic             run_eval;
    logic             stall_inc;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .load_use      (load_use)
    );

    // A MEM_WAIT cycle whose memory has just become ready behaves exactly like RUN
    assign run_eval = (state == RUN) || ((state == MEM_WAIT) && !mem_busy);

    // Zero-latency enables and next-state selection; reset forces the safe NOP-injecting pattern
    always_comb begin
        pc_write       = 1'b0;
        ifid_write     = 1'b0;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        pipe_en        = 1'b0;
        next_state     = state;
        next_drain_cnt = drain_cnt;
        next_tmo_cnt   = tmo_cnt;
        set_fault      = 1'b0;

        if (!reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (run_eval) begin
            next_state = RUN;
            if (mem_busy) begin
                next_state   = MEM_WAIT;
                next_tmo_cnt = TMO_W'(1);
            end else if (branch_taken) begin
                // The younger instruction is squashed, so any load-use on it is moot
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end else if (load_use) begin
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end else if (if_inst == HALT_INST) begin
                ifid_flush     = 1'b1;
                pipe_en        = 1'b1;
                next_state     = DRAIN;
                next_drain_cnt = '0;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                pipe_en    = 1'b1;
            end
        end else begin
            case (state)
                MEM_WAIT: begin
                    // Memory still busy here; give up after MEM_TIMEOUT consecutive busy cycles
                    next_tmo_cnt = tmo_cnt + TMO_W'(1);
                    if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
                        next_state = HALT;
                        set_fault  = 1'b1;
                    end
                end
                DRAIN: begin
                    // A frozen pipe also freezes a resolving branch, so freeze takes precedence here too
                    if (!mem_busy && branch_taken) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        pipe_en     = 1'b1;
                        next_state  = RUN;
                    end else begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        pipe_en     = !mem_busy;
                        if (!mem_busy) begin
                            if (drain_cnt == DRN_W'(DRAIN_CYCLES - 1)) begin
                                next_state = HALT;
                            end else begin
                                next_drain_cnt = drain_cnt + DRN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign halted    = (state == HALT);
    assign stall_inc = reset && (state != HALT) && !pc_write;

    // FSM, drain/timeout counters, sticky fault and saturating stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            tmo_cnt     <= '0;
            fault       <= 1'b0;
            stall_count <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain_cnt;
            tmo_cnt   <= next_tmo_cnt;
            if (set_fault) begin
                fault <= 1'b1;
            end
            if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the PC write enable, IF/ID write/flush, ID/EX bubble and global stage enable from load-use hazards, taken branches and data-memory wait.
- Owns the end-of-program sentinel (fetched instruction 32'hFFFFFFFF): drains in-flight instructions, then parks the pipeline in HALT.
- Sits beside the datapath; all pipeline registers take their enables from this block.

Parameters:
- DRAIN_CYCLES, 4, cycles to let instructions older than the sentinel retire (ID..WB).
- MEM_TIMEOUT, 64, maximum consecutive mem_busy cycles before fault halt.
- CNT_W, 16, width of the stall cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_inst  in  32  instruction currently at IF/ID input.
- ifid_rs  in  5  rs field of instruction in IF/ID.
- ifid_rt  in  5  rt field of instruction in IF/ID.
- ifid_uses_rt  in  1  instruction in IF/ID reads rt as a source.
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rt  in  5  destination rt of the load in ID/EX.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- mem_busy  in  1  data memory not ready; whole pipe must freeze.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads NOP (overrides ifid_write data).
- idex_bubble  out  1  ID/EX loads control-zero bubble.
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB.
- halted  out  1  pipeline parked (end of program or fault).
- fault  out  1  memory timeout occurred (sticky until reset).
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0 while not halted.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALT. Reset (async, reset=0): state RUN, drain_cnt=0, tmo_cnt=0, stall_count=0, fault=0, halted=0.
- Outputs are combinational from state and inputs, with zero latency. While reset=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_en=0.
- load_use = idex_mem_read & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- RUN, priority highest first:
  - mem_busy: all enables 0, no flush/bubble. Next state MEM_WAIT, tmo_cnt=1.
  - branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, pipe_en=1. Load-use is ignored, because the younger instruction is squashed.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1, pipe_en=1. Exactly one bubble per load-use pair.
  - if_inst==32'hFFFFFFFF: pc_write=0, ifid_write=0, ifid_flush=1, pipe_en=1. Next state DRAIN, drain_cnt=0.
  - else: pc_write=1, ifid_write=1, pipe_en=1, no flush/bubble.
- MEM_WAIT: all enables 0, no flush/bubble.
  - If mem_busy=0, return to RUN; RUN evaluation applies in that same cycle.
  - Else increment tmo_cnt. When tmo_cnt reaches MEM_TIMEOUT with mem_busy still 1, set fault=1 and go to HALT.
- DRAIN: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_en=!mem_busy. drain_cnt increments only when pipe_en=1.
  - branch_taken=1 (older branch, so the sentinel was wrong-path): leave DRAIN, go to RUN. Same cycle outputs equal RUN branch_taken outputs.
  - Reaching drain_cnt==DRAIN_CYCLES-1 with pipe_en=1: go to HALT.
- HALT: halted=1, all enables 0, ifid_flush=1, idex_bubble=1. Exit only via reset.
- stall_count: increments each cycle with pc_write=0 in RUN, MEM_WAIT or DRAIN. It saturates at all-ones.
- Simultaneous mem_busy and branch_taken in RUN: freeze wins. branch_taken stays asserted by the frozen EX stage and is serviced on resume.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding (2-bit RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3) and constant HALT_INST=32'hFFFFFFFF.
- One natural sub-module: hazard_detect. It is purely combinational: load_use from register fields. The FSM and counters stay in the top.

Test Plan:
- Load-use: lw with idex_rt=5, next op ifid_rs=5 -> exactly one cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_count 0->1. Same with idex_rt=0 -> no stall.
- Branch vs load-use: branch_taken=1 and load_use=1 same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_count unchanged.
- Memory wait: mem_busy high 3 cycles -> pipe_en=0 for 3 cycles, then RUN. Held 64 cycles -> fault=1, halted=1 on cycle 64.
- Sentinel: if_inst=FFFFFFFF, no stalls -> DRAIN 4 cycles with pipe_en=1, halted=1 on 5th cycle. mem_busy for 2 cycles in DRAIN -> halt delayed by 2.
- Wrong-path sentinel: branch_taken in first DRAIN cycle -> back to RUN, pc_write=1, halted stays 0.
- Async reset in DRAIN and in HALT: reset low mid-cycle -> outputs immediately take reset values; after release, state RUN with counters 0.
